// File: rtl/stream_to_1d_array_packer_pkg.sv
// Shared defaults and helpers for the stream-to-flat-array packer.
package stream_to_1d_array_packer_pkg;

  localparam int DEF_BIT_WIDTH = 4;
  localparam int DEF_COLS      = 8;

  // Width needed to hold a column count in the range 0..cols.
  function automatic int cnt_width(input int cols);
    return $clog2(cols + 1);
  endfunction

endpackage

// File: rtl/stream_to_1d_array_packer_array_slot_writer.sv
// Writes one element into slot idx_i of a flat vector. When clear_above_i is
// set, every slot above idx_i is forced to zero (used to zero-pad short words).
module array_slot_writer
  import stream_to_1d_array_packer_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int COLS      = DEF_COLS,
  parameter int IDX_W     = $clog2(COLS)
) (
  input  logic [COLS*BIT_WIDTH-1:0] vec_i,
  input  logic [BIT_WIDTH-1:0]      elem_i,
  input  logic [IDX_W-1:0]          idx_i,
  input  logic                      clear_above_i,
  output logic [COLS*BIT_WIDTH-1:0] vec_o
);

  // Slot-wise select: replace slot idx_i, optionally clear the slots above it.
  always_comb begin
    vec_o = vec_i;
    for (int i = 0; i < COLS; i++) begin
      if (i == int'(idx_i)) begin
        vec_o[i*BIT_WIDTH +: BIT_WIDTH] = elem_i;
      end else if (clear_above_i && (i > int'(idx_i))) begin
        vec_o[i*BIT_WIDTH +: BIT_WIDTH] = '0;
      end
    end
  end

endmodule

// File: rtl/stream_to_1d_array_packer.sv
// Streaming packer: collects COLS elements of BIT_WIDTH bits (column 0 in the
// LSBs) into one flat word. An in_last beat closes a word early and the unused
// upper columns are zero. Output word is held in a one-entry register slot.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Once valid is raised it stays high with stable payload until the
// transfer. in_ready depends only on out_valid/out_ready, never on in_valid.
module stream_to_1d_array_packer
  import stream_to_1d_array_packer_pkg::*;
#(
  parameter  int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter  int COLS      = DEF_COLS,
  localparam int CNT_W     = cnt_width(COLS),
  localparam int IDX_W     = $clog2(COLS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [BIT_WIDTH-1:0]      in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [COLS*BIT_WIDTH-1:0] out,
  output logic [CNT_W-1:0]          out_count,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int W = COLS * BIT_WIDTH;

  logic [IDX_W-1:0] col_q, col_d;
  logic [W-1:0]     asm_q, asm_d;
  logic [W-1:0]     out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;

  logic             in_fire;
  logic             out_fire;
  logic             complete;
  logic [W-1:0]     asm_wr;
  logic [W-1:0]     merged;

  assign in_ready = !valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = valid_q && out_ready;
  assign complete = in_last || (col_q == IDX_W'(COLS - 1));

  // Partial assembly: the new element lands in its column, nothing else moves.
  array_slot_writer #(
    .BIT_WIDTH (BIT_WIDTH),
    .COLS      (COLS),
    .IDX_W     (IDX_W)
  ) u_asm_writer (
    .vec_i         (asm_q),
    .elem_i        (in_data),
    .idx_i         (col_q),
    .clear_above_i (1'b0),
    .vec_o         (asm_wr)
  );

  // Finished word: merge the closing element and zero the unfilled columns.
  array_slot_writer #(
    .BIT_WIDTH (BIT_WIDTH),
    .COLS      (COLS),
    .IDX_W     (IDX_W)
  ) u_out_writer (
    .vec_i         (asm_q),
    .elem_i        (in_data),
    .idx_i         (col_q),
    .clear_above_i (1'b1),
    .vec_o         (merged)
  );

  // Next-state: drain the output slot, then accept a beat (a completing beat
  // refills the slot in the same cycle so back-to-back words need no bubble).
  always_comb begin
    col_d   = col_q;
    asm_d   = asm_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (out_fire) begin
      valid_d = 1'b0;
    end
    if (in_fire) begin
      if (complete) begin
        out_d   = merged;
        cnt_d   = CNT_W'(col_q) + CNT_W'(1);
        valid_d = 1'b1;
        asm_d   = '0;
        col_d   = '0;
      end else begin
        asm_d   = asm_wr;
        col_d   = col_q + IDX_W'(1);
      end
    end
  end

  // State registers; reset discards any partial or pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      asm_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      asm_q   <= asm_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign out       = out_q;
  assign out_count = cnt_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_stream_to_1d_array_packer.sv
// Bench for stream_to_1d_array_packer (BIT_WIDTH=4, COLS=8): directed steps
// plus a random phase, all outputs compared to an element-list reference.
module tb_stream_to_1d_array_packer;

  localparam int BW   = 4;
  localparam int COLS = 8;
  localparam int W    = BW * COLS;
  localparam int CW   = $clog2(COLS + 1);

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [W-1:0]  out;
  logic [CW-1:0] out_count;
  logic          out_valid;
  logic          out_ready = 1'b1;

  always #5 clk = ~clk;

  stream_to_1d_array_packer #(
    .BIT_WIDTH (BW),
    .COLS      (COLS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out       (out),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // ---------------- scoreboard / reference ----------------
  int errors = 0;
  int checks = 0;
  int words_out = 0;
  int stalls = 0;
  bit mon_en = 1'b0;

  logic [W-1:0]  exp_q[$];
  logic [CW-1:0] cnt_q[$];
  logic [BW-1:0] cur_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: a word is the list of accepted elements, packed column 0 first.
  function automatic logic [W-1:0] pack_cur();
    logic [W-1:0] w = '0;
    for (int i = 0; i < cur_q.size(); i++) w[i*BW +: BW] = cur_q[i];
    return w;
  endfunction

  // Monitor: compare at negedge, then advance the reference at the posedge.
  bit            plan_v = 1'b0;
  bit            p_out_fire, p_in_fire, p_last;
  logic [BW-1:0] p_data;
  always begin
    @(negedge clk);
    plan_v = 1'b0;
    if (!rst_n) begin
      if (mon_en) check("valid_in_reset", out_valid, 1'b0);
    end else if (mon_en) begin
      check("in_ready", in_ready, (exp_q.size() == 0) || out_ready);
      check("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("out_word", out, exp_q[0]);
        check("out_count", out_count, cnt_q[0]);
      end
      p_out_fire = (exp_q.size() != 0) && out_ready;
      p_in_fire  = in_valid && ((exp_q.size() == 0) || out_ready);
      p_data     = in_data;
      p_last     = in_last;
      plan_v     = 1'b1;
    end
    @(posedge clk);
    if (plan_v && rst_n) begin
      if (p_out_fire) begin
        void'(exp_q.pop_front());
        void'(cnt_q.pop_front());
        words_out++;
      end
      if (p_in_fire) begin
        cur_q.push_back(p_data);
        if (p_last || cur_q.size() == COLS) begin
          exp_q.push_back(pack_cur());
          cnt_q.push_back(CW'(cur_q.size()));
          cur_q.delete();
        end
      end
    end
    plan_v = 1'b0;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [BW-1:0] d, input logic l);
    int   tries = 0;
    logic acc = 1'b0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!acc && tries < 100) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      tries++;
    end
    if (tries > 1) stalls++;
    if (!acc) check("send_timeout", acc, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic model_clear();
    exp_q.delete();
    cnt_q.delete();
    cur_q.delete();
  endtask

  // ---------------- directed + random steps ----------------
  initial begin
    int w0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", out, '0);
    check("rst_count", out_count, '0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();

    // Full word 1..8, in_last on the 8th beat; valid one cycle later.
    for (int i = 1; i <= 8; i++) send(BW'(i), i == 8);
    check("full_valid", out_valid, 1'b1);
    check("full_word", out, 32'h87654321);
    check("full_count", out_count, 4'd8);
    tick();

    // Short word closed by in_last.
    send(4'hA, 1'b0);
    send(4'hB, 1'b0);
    send(4'hC, 1'b1);
    check("short_word", out, 32'h00000CBA);
    check("short_count", out_count, 4'd3);

    // Single element with in_last at column 0 (also proves column restart).
    send(4'hF, 1'b1);
    check("single_word", out, 32'h0000000F);
    check("single_count", out_count, 4'd1);
    tick();

    // Back-to-back streaming of 24 elements with no in_last.
    w0     = words_out;
    stalls = 0;
    for (int i = 0; i < 24; i++) send(BW'(i % 16), 1'b0);
    tick();
    tick();
    check("b2b_words", words_out - w0, 3);
    check("b2b_stalls", stalls, 0);

    // Backpressure: word held and in_ready low for 5 cycles.
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(BW'(i), 1'b0);
    in_data  = 4'h9;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_hold_word", out, 32'h87654321);
      check("bp_hold_valid", out_valid, 1'b1);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("bp_next_valid", out_valid, 1'b1);
    check("bp_next_word", out, 32'h00000009);
    check("bp_next_count", out_count, 4'd1);
    tick();

    // Reset mid-word after 4 elements.
    for (int i = 0; i < 4; i++) send(4'h5 + BW'(i), 1'b0);
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_out", out, '0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) send(BW'(i), 1'b0);
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_word", out, 32'h87654321);
    check("post_rst_count", out_count, 4'd8);
    tick();

    // Random phase against the reference.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = BW'($urandom_range(0, 15));
      in_last   = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("drain_valid", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
